controlador_io: RTL and testbench
=================================

// Module: controlador_io
// PURPOSE
//  Sequences the IN, OUT and HALT instructions decoded by the control unit. Owns PC stall.
//  Debounces the two user push-buttons and captures switch data for IN.
//  Holds the display register for OUT.
//  Sits between the control-unit decode strobes, the register-file write port and board I/O.
// PARAMETERS
//  DATA_WIDTH       32  width of register-file data, outData, inData and display
//  SW_WIDTH         16  number of board switches (<= DATA_WIDTH)
//  DEBOUNCE_CYCLES  4   consecutive stable samples for a button level change (>= 1)
// PORTS
//  clock         in   1           system clock, rising edge
//  reset         in   1           asynchronous, active-high system reset
//  isIn          in   1           decoded IN instruction in current cycle
//  isOut         in   1           decoded OUT instruction in current cycle
//  isHalt        in   1           decoded HALT instruction in current cycle
//  btnConfirm    in   1           raw, asynchronous, bouncing key that confirms IN data
//  btnResume     in   1           raw, asynchronous, bouncing key that leaves HALT
//  switches      in   SW_WIDTH    raw board switches, IN data source
//  outData       in   DATA_WIDTH  register value presented by OUT
//  stall         out  1           holds PC (combinational)
//  inData        out  DATA_WIDTH  captured switches, zero-extended
//  inValid       out  1           one-cycle register-file write enable for IN
//  display       out  DATA_WIDTH  last OUT value
//  displayValid  out  1           high once any OUT has executed since reset
//  halted        out  1           state == HALTED
// BEHAVIOUR
//  Reset (async):
//   - All outputs 0; state=IDLE.
//   - Synchronisers, debounced levels and counters are 0.
//   - Reset while in IN_WAIT, IN_DONE or HALTED aborts: no inValid pulse, inData unchanged at 0.
//  Button path, identical for each key:
//   - 2-FF synchroniser; sync value s.
//   - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1), compared with debounced level deb.
//   - Each edge: if s==deb then cnt<=0.
//   - Else if cnt==DEBOUNCE_CYCLES-1 then deb<=s and cnt<=0; else cnt<=cnt+1.
//   - press = deb & ~deb_q (deb_q = deb delayed one cycle); exactly one cycle wide.
//   - Latency: raw high first sampled at edge 1 -> press high in the cycle after edge DEBOUNCE_CYCLES+2.
//   - Press pulses in any state other than the one consuming them are discarded, never queued.
//   - A key already held when waiting begins produces no press until it is released and pressed again.
//  FSM states: IDLE, IN_WAIT, IN_DONE, HALTED.
//   - Decode priority if several strobes are high: isHalt > isIn > isOut.
//   - IDLE & isHalt -> HALTED; stall=1 this cycle.
//   - IDLE & isIn -> IN_WAIT; stall=1 this cycle.
//   - IDLE & isOut: display<=outData, displayValid<=1 at this edge; stay IDLE; stall=0. OUT never stalls.
//   - IN_WAIT: stall=1.
//     - pressConfirm: inData<={0,switches} (synchronised switches), -> IN_DONE.
//     - isIn/isOut/isHalt are ignored while not IDLE (PC is frozen).
//   - IN_DONE: stall=0, inValid=1 for this single cycle; PC advances; -> IDLE.
//   - HALTED: stall = ~pressResume; halted=1.
//     - pressResume -> IDLE; PC advances in that same cycle.
//     - btnConfirm is ignored.
//  - inData holds its value until the next IN capture.
//  - display holds its value until the next OUT or reset.
//  - Switches pass through their own 2-FF synchroniser; they are not debounced.
// TESTING (DEBOUNCE_CYCLES=4)
//  1 Reset: assert reset asynchronously in IN_WAIT between edges -> stall, inValid, display, displayValid, halted=0 immediately; state IDLE.
//  2 IN: switches=16'hA5A5; pulse isIn; btnConfirm high from edge 10
//    -> stall=1 from isIn cycle; press in cycle after edge 15;
//    -> next cycle inValid=1, inData=32'h0000A5A5, stall=0; then IDLE.
//  3 Bounce in IN_WAIT: btnConfirm toggles every 2 cycles for 20 cycles -> no press, inValid stays 0, stall stays 1.
//  4 Pre-held key: btnConfirm high before isIn -> no capture.
//    Release for 6 cycles, press again -> capture per scenario 2 timing.
//  5 OUT: outData=32'hDEADBEEF with isOut -> display=32'hDEADBEEF and displayValid=1 after the edge; stall never 1.
//    A second OUT of 32'h1 overwrites display.
//  6 HALT: isHalt -> halted=1, stall=1; btnConfirm press ignored.
//    btnResume press -> stall=0 for the press cycle, then IDLE with halted=0.

Source files
------------

// File: rtl/controlador_io.sv
// I/O sequencer for IN, OUT and HALT: stalls the PC, debounces the confirm/resume keys,
// captures synchronised switches for IN and holds the display register for OUT.
module controlador_io #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  isIn,
  input  logic                  isOut,
  input  logic                  isHalt,
  input  logic                  btnConfirm,
  input  logic                  btnResume,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic [DATA_WIDTH-1:0] outData,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] inData,
  output logic                  inValid,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  displayValid,
  output logic                  halted
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int BTN_CONFIRM = 0;
  localparam int BTN_RESUME  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_WAIT = 2'd1,
    IN_DONE = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            btn_raw;
  logic [1:0]            btn_meta_q, btn_sync_q;
  logic [1:0]            deb_q, deb_dly_q;
  logic [CNT_W-1:0]      cnt_q [2];
  logic [1:0]            press;
  logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;
  logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic [DATA_WIDTH-1:0] display_q, display_d;
  logic                  disp_valid_q, disp_valid_d;

  assign btn_raw = {btnResume, btnConfirm};

  // Both keys share one synchroniser/debouncer structure; a level change needs
  // DEBOUNCE_CYCLES consecutive disagreeing samples before deb follows it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      deb_dly_q  <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= btn_sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      state_q      <= IDLE;
      in_data_q    <= '0;
      display_q    <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      sw_meta_q    <= switches;
      sw_sync_q    <= sw_meta_q;
      state_q      <= state_d;
      in_data_q    <= in_data_d;
      display_q    <= display_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // Strobes are only decoded in IDLE; elsewhere the PC is frozen and press
  // pulses not consumed by the current state are simply dropped.
  always_comb begin
    state_d      = state_q;
    in_data_d    = in_data_q;
    display_d    = display_q;
    disp_valid_d = disp_valid_q;
    stall        = 1'b0;
    inValid      = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (isHalt) begin
          state_d = HALTED;
          stall   = 1'b1;
        end else if (isIn) begin
          state_d = IN_WAIT;
          stall   = 1'b1;
        end else if (isOut) begin
          display_d    = outData;
          disp_valid_d = 1'b1;
        end
      end
      IN_WAIT: begin
        stall = 1'b1;
        if (press[BTN_CONFIRM]) begin
          in_data_d = DATA_WIDTH'(sw_sync_q);
          state_d   = IN_DONE;
        end
      end
      IN_DONE: begin
        inValid = 1'b1;
        state_d = IDLE;
      end
      HALTED: begin
        halted = 1'b1;
        stall  = ~press[BTN_RESUME];
        if (press[BTN_RESUME]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inData       = in_data_q;
  assign display      = display_q;
  assign displayValid = disp_valid_q;

endmodule

// File: tb/tb_controlador_io.sv
// Bench for controlador_io: scenario tasks with inline checks; IN captures are
// scoreboarded and matched against every observed inValid pulse.
`timescale 1ns/1ps
module tb_controlador_io;

  logic        clk = 1'b0;
  logic        reset;
  logic        isIn, isOut, isHalt;
  logic        btnConfirm, btnResume;
  logic [15:0] switches;
  logic [31:0] outData;
  logic        stall, inValid, displayValid, halted;
  logic [31:0] inData, display;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  controlador_io #(.DATA_WIDTH(32), .SW_WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clk), .reset(reset), .isIn(isIn), .isOut(isOut), .isHalt(isHalt),
    .btnConfirm(btnConfirm), .btnResume(btnResume), .switches(switches),
    .outData(outData), .stall(stall), .inData(inData), .inValid(inValid),
    .display(display), .displayValid(displayValid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Every inValid pulse must match the oldest outstanding capture.
  always @(negedge clk) begin
    if (inValid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_inValid: got inData=%h with no capture expected", inData);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (inData !== e) begin
          fails++;
          $display("FAIL sb_inData: got %h want %h", inData, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assumes IN_WAIT with confirm key released and settled.
  task automatic press_and_capture(input string nm);
    btnConfirm = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      tests++;
      if (stall !== 1'b1 || inValid !== 1'b0) begin
        fails++;
        $display("FAIL %s_wait_e%0d: got stall=%b inValid=%b want 1 0", nm, k, stall, inValid);
      end
    end
    exp_q.push_back({16'h0000, switches});
    step(1);
    tests++;
    if (inValid !== 1'b1 || stall !== 1'b0 || inData !== {16'h0000, switches}) begin
      fails++;
      $display("FAIL %s_done: got inValid=%b stall=%b inData=%h want 1 0 %h",
               nm, inValid, stall, inData, {16'h0000, switches});
    end
    step(1);
    tests++;
    if (inValid !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: got inValid=%b stall=%b want 0 0", nm, inValid, stall);
    end
    btnConfirm = 1'b0;
    step(8);
  endtask

  task automatic enter_in_wait(input string nm);
    isIn = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL %s_isIn_stall: got %b want 1", nm, stall);
    end
    step(1);
    isIn = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL %s_inwait_stall: got %b want 1", nm, stall);
    end
  endtask

  task automatic test_power_on;
    reset = 1'b1;
    isIn = 0; isOut = 0; isHalt = 0; btnConfirm = 0; btnResume = 0;
    switches = '0; outData = '0;
    step(2);
    tests++;
    if ({stall, inValid, displayValid, halted} !== 4'b0 || inData !== '0 || display !== '0) begin
      fails++;
      $display("FAIL por_outputs: got stall=%b inValid=%b dV=%b halted=%b inData=%h display=%h want all 0",
               stall, inValid, displayValid, halted, inData, display);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_in;
    switches = 16'hA5A5;
    step(3);
    enter_in_wait("in");
    press_and_capture("in");
  endtask

  task automatic test_bounce;
    switches = 16'h1234;
    step(3);
    enter_in_wait("bounce");
    for (int i = 0; i < 20; i++) begin
      btnConfirm = ((i / 2) % 2) != 0;
      step(1);
      tests++;
      if (stall !== 1'b1 || inValid !== 1'b0) begin
        fails++;
        $display("FAIL bounce_c%0d: got stall=%b inValid=%b want 1 0", i, stall, inValid);
      end
    end
    btnConfirm = 1'b0;
    step(8);
    press_and_capture("bounce_exit");
  endtask

  task automatic test_preheld;
    switches = 16'hFFFF;
    btnConfirm = 1'b1;
    step(10);
    enter_in_wait("preheld");
    for (int i = 0; i < 10; i++) begin
      step(1);
      tests++;
      if (stall !== 1'b1 || inValid !== 1'b0) begin
        fails++;
        $display("FAIL preheld_c%0d: got stall=%b inValid=%b want 1 0", i, stall, inValid);
      end
    end
    btnConfirm = 1'b0;
    step(6);
    press_and_capture("preheld_again");
  endtask

  task automatic test_out;
    outData = 32'hDEADBEEF;
    isOut = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0 || displayValid !== 1'b0) begin
      fails++;
      $display("FAIL out1_pre: got stall=%b dV=%b want 0 0", stall, displayValid);
    end
    step(1);
    isOut = 1'b0;
    tests++;
    if (display !== 32'hDEADBEEF || displayValid !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL out1: got display=%h dV=%b stall=%b want deadbeef 1 0", display, displayValid, stall);
    end
    outData = 32'h0000_0001;
    isOut = 1'b1;
    step(1);
    isOut = 1'b0;
    outData = 32'h5555_5555;
    step(2);
    tests++;
    if (display !== 32'h1 || displayValid !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL out2: got display=%h dV=%b stall=%b want 00000001 1 0", display, displayValid, stall);
    end
  endtask

  task automatic test_halt;
    isHalt = 1'b1; isIn = 1'b1; isOut = 1'b1; outData = 32'h77;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL halt_strobe_stall: got %b want 1", stall);
    end
    step(1);
    isHalt = 1'b0; isIn = 1'b0; isOut = 1'b0;
    tests++;
    if (halted !== 1'b1 || stall !== 1'b1 || display !== 32'h1) begin
      fails++;
      $display("FAIL halt_enter: got halted=%b stall=%b display=%h want 1 1 00000001", halted, stall, display);
    end
    btnConfirm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      tests++;
      if (halted !== 1'b1 || stall !== 1'b1 || inValid !== 1'b0) begin
        fails++;
        $display("FAIL halt_confirm_c%0d: got halted=%b stall=%b inValid=%b want 1 1 0",
                 i, halted, stall, inValid);
      end
    end
    btnConfirm = 1'b0;
    step(8);
    isIn = 1'b1;
    step(1);
    isIn = 1'b0;
    tests++;
    if (halted !== 1'b1 || stall !== 1'b1) begin
      fails++;
      $display("FAIL halt_isIn_ignored: got halted=%b stall=%b want 1 1", halted, stall);
    end
    btnResume = 1'b1;
    step(5);
    tests++;
    if (halted !== 1'b1 || stall !== 1'b1) begin
      fails++;
      $display("FAIL halt_pre_resume: got halted=%b stall=%b want 1 1", halted, stall);
    end
    step(1);
    tests++;
    if (halted !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL halt_resume_cycle: got halted=%b stall=%b want 1 0", halted, stall);
    end
    step(1);
    tests++;
    if (halted !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL halt_exit: got halted=%b stall=%b want 0 0", halted, stall);
    end
    btnResume = 1'b0;
    step(8);
  endtask

  task automatic test_reset;
    enter_in_wait("rst");
    step(2);
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({stall, inValid, displayValid, halted} !== 4'b0 || display !== '0 || inData !== '0) begin
      fails++;
      $display("FAIL rst_async: got stall=%b inValid=%b dV=%b halted=%b display=%h inData=%h want all 0",
               stall, inValid, displayValid, halted, display, inData);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    step(1);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle_stall: got %b want 0", stall);
    end
    btnConfirm = 1'b1;
    step(10);
    tests++;
    if (stall !== 1'b0 || inValid !== 1'b0 || inData !== '0) begin
      fails++;
      $display("FAIL rst_no_capture: got stall=%b inValid=%b inData=%h want 0 0 0", stall, inValid, inData);
    end
    btnConfirm = 1'b0;
    step(8);
  endtask

  initial begin
    test_power_on();
    test_in();
    test_bounce();
    test_preheld();
    test_out();
    test_halt();
    test_reset();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_pending: got %0d captures never seen, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
